// File: rtl/hex_key_entry_pkg.sv
// Shared constants and types for the push-button hex entry block.
package hex_key_entry_pkg;

  localparam int KEY_CANCEL = 0;
  localparam int KEY_INC    = 1;
  localparam int KEY_NEXT   = 2;
  localparam int KEY_COMMIT = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EDIT = 1'b1
  } state_t;

  // A single-digit editor still needs a 1-bit cursor port.
  function automatic int cursor_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/hex_key_entry_if.sv
// Button inputs and editor outputs of hex_key_entry; slave is the editor side.
interface hex_key_entry_if
  import hex_key_entry_pkg::*;
#(
  parameter int DIGITS = 2
);

  localparam int CW = cursor_width(DIGITS);

  logic [3:0]          key_n;
  logic [4*DIGITS-1:0] value;
  logic [CW-1:0]       cursor;
  logic                editing;
  logic [4*DIGITS-1:0] result;
  logic                result_valid;

  modport master (
    output key_n,
    input  value, cursor, editing, result, result_valid
  );

  modport slave (
    input  key_n,
    output value, cursor, editing, result, result_valid
  );

endinterface

// File: rtl/hex_key_entry_key_debounce.sv
// One button: 2-FF synchronizer, stability counter, registered press pulse.
// Pulse appears DEBOUNCE_CYCLES+2 edges after the first low sample; no backpressure.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pressed
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          stable_dly_q, stable_dly_d;
  logic          pressed_q, pressed_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d      = key_n;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    cnt_d        = '0;
    pressed_d    = stable_dly_q & ~stable_q;
    // The sample that would bring the count to DEBOUNCE_CYCLES flips stable instead.
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      pressed_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      pressed_q    <= pressed_d;
      cnt_q        <= cnt_d;
    end
  end

  assign pressed = pressed_q;

endmodule

// File: rtl/hex_key_entry.sv
// Hex value editor driven by four debounced push-buttons (CANCEL, INC, NEXT, COMMIT).
// A press reaches the outputs DEBOUNCE_CYCLES+3 edges after its first low sample; no backpressure.
module hex_key_entry
  import hex_key_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DIGITS          = 2
) (
  input  logic            clk,
  input  logic            rst,
  hex_key_entry_if.slave  bus
);

  localparam int            CW       = cursor_width(DIGITS);
  localparam logic [CW-1:0] CUR_LAST = CW'(DIGITS - 1);

  logic [3:0] pressed;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .key_n  (bus.key_n[i]),
      .pressed(pressed[i])
    );
  end

  logic ev_cancel, ev_commit, ev_next, ev_inc;

  always_comb begin
    ev_cancel = pressed[KEY_CANCEL];
    ev_commit = pressed[KEY_COMMIT] & ~ev_cancel;
    ev_next   = pressed[KEY_NEXT] & ~pressed[KEY_COMMIT] & ~ev_cancel;
    ev_inc    = pressed[KEY_INC] & ~pressed[KEY_NEXT] & ~pressed[KEY_COMMIT] & ~ev_cancel;
  end

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [4*DIGITS-1:0] result_q, result_d;
  logic [CW-1:0]       cursor_q, cursor_d;
  logic                result_valid_q, result_valid_d;
  int                  dig_lsb;

  always_comb begin
    state_d        = state_q;
    value_d        = value_q;
    result_d       = result_q;
    cursor_d       = cursor_q;
    result_valid_d = 1'b0;
    dig_lsb        = 4 * int'(cursor_q);
    case (state_q)
      ST_IDLE: begin
        // Waking press only opens the editor; it is not applied to the value.
        if (ev_next || ev_inc) begin
          state_d  = ST_EDIT;
          cursor_d = '0;
        end
      end
      ST_EDIT: begin
        if (ev_cancel) begin
          value_d = result_q;
          state_d = ST_IDLE;
        end else if (ev_commit) begin
          result_d       = value_q;
          result_valid_d = 1'b1;
          state_d        = ST_IDLE;
        end else if (ev_next) begin
          cursor_d = (cursor_q == CUR_LAST) ? '0 : cursor_q + CW'(1);
        end else if (ev_inc) begin
          value_d[dig_lsb +: 4] = value_q[dig_lsb +: 4] + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      value_q        <= '0;
      result_q       <= '0;
      cursor_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      value_q        <= value_d;
      result_q       <= result_d;
      cursor_q       <= cursor_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bus.value        = value_q;
  assign bus.result       = result_q;
  assign bus.cursor       = cursor_q;
  assign bus.editing      = (state_q == ST_EDIT);
  assign bus.result_valid = result_valid_q;

endmodule
